vga_display_engine: RTL

Parametrised VGA timing and pixel-output engine, successor to the fixed 640x480 controller. Generates configurable horizontal/vertical timing, issues pixel-fetch coordinates and a linear frame-buffer address ahead of display, and realigns sync/blank with returned pixel data for a configurable fetch latency. Adds frame-aligned enable/disable and built-in test-pattern modes. Sits between the screen-memory reader and the VGA DAC pins, entirely in the `vga_clk` domain.

---
 rtl/vga_display_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_display_engine.sv
// vga_display_engine: parametrised VGA timing with fetch-ahead addressing,
// latency-aligned sync/blank/colour pins and built-in test patterns.
module vga_display_engine #(
  parameter int   H_ACTIVE      = 640,
  parameter int   H_FP          = 16,
  parameter int   H_SYNC        = 96,
  parameter int   H_BP          = 48,
  parameter int   V_ACTIVE      = 480,
  parameter int   V_FP          = 10,
  parameter int   V_SYNC        = 2,
  parameter int   V_BP          = 33,
  parameter logic HS_POL        = 1'b0,
  parameter logic VS_POL        = 1'b0,
  parameter int   COLOR_W       = 8,
  parameter int   FETCH_LATENCY = 2,
  parameter int   ADDR_W        = 19
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   pixel,
  output logic [10:0]            next_pixel_h,
  output logic [10:0]            next_pixel_v,
  output logic [ADDR_W-1:0]      next_pixel_addr,
  output logic                   fetch_valid,
  output logic                   HS,
  output logic                   VS,
  output logic                   blank_n,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W > 0) ? BAR_W : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [1:0]  mode;
    logic [10:0] h;
    logic [10:0] v;
  } tap_t;

  state_t              state, state_nx;
  logic                live, h_last, eof;
  logic                nx_act, fs_nx;
  logic [10:0]         h_nx, v_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [1:0]          mode_q;

  assign live   = state != IDLE;
  assign h_last = next_pixel_h == 11'(H_TOTAL - 1);
  assign eof    = h_last && next_pixel_v == 11'(V_TOTAL - 1);

  // DRAIN keeps scanning so a dropped enable never cuts a frame short
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = RUN;
      default: state_nx = enable ? RUN : (eof ? IDLE : DRAIN);
    endcase
  end

  always_comb begin
    h_nx = '0;
    v_nx = '0;
    if (live && state_nx != IDLE) begin
      h_nx = h_last ? '0 : next_pixel_h + 11'd1;
      if (!h_last)  v_nx = next_pixel_v;
      else if (!eof) v_nx = next_pixel_v + 11'd1;
    end
    nx_act = state_nx != IDLE
          && h_nx < 11'(H_ACTIVE)
          && v_nx < 11'(V_ACTIVE);
    fs_nx  = state_nx != IDLE && h_nx == '0 && v_nx == '0;
    if (fs_nx || state_nx == IDLE) addr_nx = '0;
    else if (fetch_valid) addr_nx = next_pixel_addr + ADDR_W'(1);
    else addr_nx = next_pixel_addr;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      next_pixel_h    <= '0;
      next_pixel_v    <= '0;
      next_pixel_addr <= '0;
      fetch_valid     <= 1'b0;
      frame_start     <= 1'b0;
      mode_q          <= '0;
    end else begin
      next_pixel_h    <= h_nx;
      next_pixel_v    <= v_nx;
      next_pixel_addr <= addr_nx;
      fetch_valid     <= nx_act;
      frame_start     <= fs_nx;
      if (fs_nx) mode_q <= mode;
    end
  end

  tap_t req, tap;

  always_comb begin
    req      = '0;
    req.hs   = live
            && next_pixel_h >= 11'(HS_BEG)
            && next_pixel_h <  11'(HS_END);
    req.vs   = live
            && next_pixel_v >= 11'(VS_BEG)
            && next_pixel_v <  11'(VS_END);
    req.act  = fetch_valid;
    req.mode = mode_q;
    req.h    = next_pixel_h;
    req.v    = next_pixel_v;
  end

  generate
    if (FETCH_LATENCY == 0) begin : g_nodly
      assign tap = req;
    end else begin : g_dly
      tap_t dly [FETCH_LATENCY];
      always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
          dly <= '{default: '0};
        end else begin
          dly[0] <= req;
          for (int i = 1; i < FETCH_LATENCY; i++)
            dly[i] <= dly[i-1];
        end
      end
      assign tap = dly[FETCH_LATENCY-1];
    end
  endgenerate

  logic [10:0]          bar_idx;
  logic [2:0]           bar;
  logic                 border;
  logic [3*COLOR_W-1:0] rgb;

  always_comb begin
    bar_idx = tap.h / 11'(BAR_DIV);
    bar     = 3'b000;
    if (BAR_W > 0 && bar_idx < 11'd8)
      bar = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
    border = tap.h == '0
          || tap.h == 11'(H_ACTIVE - 1)
          || tap.v == '0
          || tap.v == 11'(V_ACTIVE - 1);
    rgb = pixel;
    unique case (tap.mode)
      2'd1: rgb = {{COLOR_W{bar[2]}},
                   {COLOR_W{bar[1]}},
                   {COLOR_W{bar[0]}}};
      2'd2: rgb = {3*COLOR_W{tap.h[3] ^ tap.v[3]}};
      2'd3: if (border) rgb = '1;
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      HS      <= ~HS_POL;
      VS      <= ~VS_POL;
      blank_n <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      HS      <= tap.hs ? HS_POL : ~HS_POL;
      VS      <= tap.vs ? VS_POL : ~VS_POL;
      blank_n <= tap.act;
      {red, green, blue} <= tap.act ? rgb : '0;
    end
  end

endmodule
